rgb_hsv_stream: RTL



---
 rtl/rgb_hsv_pkg.sv | 23 ++
 rtl/rgb_hsv_stream_divider.sv | 84 ++++++++
 rtl/rgb_hsv_stream.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rgb_hsv_pkg.sv
// Shared constants and helpers for the RGB->HSV stream converter.
package rgb_hsv_pkg;

  localparam int HUE_DEG_K      = 60;
  localparam int HUE_BYTE_K     = 43;
  localparam int HUE_DEG_OFF_G  = 120;
  localparam int HUE_DEG_OFF_B  = 240;
  localparam int HUE_BYTE_OFF_G = 85;
  localparam int HUE_BYTE_OFF_B = 171;
  localparam int HUE_DEG_WRAP   = 360;
  localparam int HUE_BYTE_WRAP  = 256;

  typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B} max_sel_e;

  function automatic int hue_width(input int hue_mode);
    return (hue_mode == 0) ? 9 : 8;
  endfunction

  function automatic int lat(input int cw);
    return cw + 3;
  endfunction

endpackage

// File: rtl/rgb_hsv_stream_divider.sv
// Pipelined restoring divider, one quotient bit per stage; QW cycles of en, holds when en=0.
// A zero divisor yields a zero quotient.
module hsv_pipe_divider #(
  parameter int NW = 14,
  parameter int DW = 8,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_vld,
  input  logic [NW-1:0] in_num,
  input  logic [DW-1:0] in_den,
  output logic          out_vld,
  output logic [QW-1:0] out_quo
);
  localparam int RW = (NW > DW + QW) ? NW : DW + QW;

  logic [RW-1:0] rem_q [QW];
  logic [RW-1:0] rem_d [QW];
  logic [DW-1:0] den_q [QW];
  logic [DW-1:0] den_d [QW];
  logic [QW-1:0] quo_q [QW];
  logic [QW-1:0] quo_d [QW];
  logic [QW-1:0] vld_q, vld_d;

  logic [RW-1:0] rem_in [QW];
  logic [RW-1:0] trial  [QW];
  logic [DW-1:0] den_in [QW];
  logic [QW-1:0] quo_in [QW];
  logic [QW-1:0] vld_in;
  logic [QW-1:0] take;

  always_comb begin
    rem_in[0] = RW'(in_num);
    den_in[0] = in_den;
    quo_in[0] = '0;
    vld_in    = '0;
    vld_in[0] = in_vld;
    for (int s = 1; s < QW; s++) begin
      rem_in[s] = rem_q[s-1];
      den_in[s] = den_q[s-1];
      quo_in[s] = quo_q[s-1];
      vld_in[s] = vld_q[s-1];
    end
  end

  // Stage s resolves quotient bit QW-1-s by trial-subtracting the shifted divisor.
  always_comb begin
    rem_d = rem_q;
    den_d = den_q;
    quo_d = quo_q;
    vld_d = vld_q;
    take  = '0;
    for (int s = 0; s < QW; s++) begin
      trial[s] = RW'(den_in[s]) << (QW - 1 - s);
      take[s]  = (den_in[s] != '0) && (rem_in[s] >= trial[s]);
      if (en) begin
        vld_d[s] = vld_in[s];
        den_d[s] = den_in[s];
        rem_d[s] = take[s] ? (rem_in[s] - trial[s]) : rem_in[s];
        quo_d[s] = take[s] ? (quo_in[s] | (QW'(1) << (QW - 1 - s))) : quo_in[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '{default: '0};
      den_q <= '{default: '0};
      quo_q <= '{default: '0};
      vld_q <= '0;
    end else begin
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
      vld_q <= vld_d;
    end
  end

  assign out_vld = vld_q[QW-1];
  assign out_quo = quo_q[QW-1];

endmodule

// File: rtl/rgb_hsv_stream.sv
// Streaming RGB->HSV converter; CW+3 cycles of en latency, one pixel per clock.
// Whole pipeline stalls in place while out_valid && !out_ready; no internal buffering.
module rgb_hsv_stream
  import rgb_hsv_pkg::*;
#(
  parameter int CW       = 8,
  parameter int HUE_MODE = 0,
  parameter int SBW      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CW-1:0]                  in_r,
  input  logic [CW-1:0]                  in_g,
  input  logic [CW-1:0]                  in_b,
  input  logic [SBW-1:0]                 in_sb,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [hue_width(HUE_MODE)-1:0] out_h,
  output logic [CW-1:0]                  out_s,
  output logic [CW-1:0]                  out_v,
  output logic [SBW-1:0]                 out_sb
);
  localparam int HW    = hue_width(HUE_MODE);
  localparam int K     = (HUE_MODE == 0) ? HUE_DEG_K     : HUE_BYTE_K;
  localparam int OFF_G = (HUE_MODE == 0) ? HUE_DEG_OFF_G : HUE_BYTE_OFF_G;
  localparam int OFF_B = (HUE_MODE == 0) ? HUE_DEG_OFF_B : HUE_BYTE_OFF_B;
  localparam int WRAP  = (HUE_MODE == 0) ? HUE_DEG_WRAP  : HUE_BYTE_WRAP;
  localparam int HNW   = CW + 6;
  localparam int MW    = 1 + HW + 1 + CW + SBW;

  logic en;

  logic           s1_vld_q, s1_vld_d;
  logic [CW-1:0]  s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
  logic [CW-1:0]  s1_max_q, s1_max_d, s1_delta_q, s1_delta_d;
  max_sel_e       s1_sel_q, s1_sel_d;
  logic [SBW-1:0] s1_sb_q, s1_sb_d;

  logic            s2_vld_q, s2_vld_d;
  logic [HNW-1:0]  s2_hnum_q, s2_hnum_d;
  logic [2*CW-1:0] s2_snum_q, s2_snum_d;
  logic [CW-1:0]   s2_delta_q, s2_delta_d;
  logic [MW-1:0]   s2_meta_q, s2_meta_d;
  logic [CW-1:0]   s2_max;

  logic [MW-1:0] meta_q [CW];
  logic [MW-1:0] meta_d [CW];

  logic           out_vld_q, out_vld_d;
  logic [HW-1:0]  out_h_q, out_h_d;
  logic [CW-1:0]  out_s_q, out_s_d, out_v_q, out_v_d;
  logic [SBW-1:0] out_sb_q, out_sb_d;

  logic           h_vld, s_vld;
  logic [CW-1:0]  q_h, q_s;
  logic           m_neg, m_dz;
  logic [HW-1:0]  m_off;
  logic [CW-1:0]  m_max;
  logic [SBW-1:0] m_sb;

  logic [CW-1:0] mx, mn, adiff;
  max_sel_e      sel;
  logic [CW:0]   diff;
  logic          neg;
  logic [HW-1:0] off;
  int            h_int;

  assign en        = !out_vld_q || out_ready;
  assign in_ready  = en;
  assign s2_max    = s2_meta_q[SBW +: CW];
  assign {m_neg, m_off, m_dz, m_max, m_sb} = meta_q[CW-1];

  always_comb begin
    s1_vld_d = s1_vld_q;  s1_r_d = s1_r_q;  s1_g_d = s1_g_q;  s1_b_d = s1_b_q;
    s1_max_d = s1_max_q;  s1_delta_d = s1_delta_q;  s1_sel_d = s1_sel_q;  s1_sb_d = s1_sb_q;
    s2_vld_d = s2_vld_q;  s2_hnum_d = s2_hnum_q;  s2_snum_d = s2_snum_q;
    s2_delta_d = s2_delta_q;  s2_meta_d = s2_meta_q;
    meta_d = meta_q;
    out_vld_d = out_vld_q;  out_h_d = out_h_q;  out_s_d = out_s_q;
    out_v_d = out_v_q;  out_sb_d = out_sb_q;

    // Strict compares give R, then G, then B priority on ties.
    mx = in_r;  mn = in_r;  sel = SEL_R;
    if (in_g > mx) begin mx = in_g; sel = SEL_G; end
    if (in_b > mx) begin mx = in_b; sel = SEL_B; end
    if (in_g < mn) mn = in_g;
    if (in_b < mn) mn = in_b;

    case (s1_sel_q)
      SEL_G:   begin diff = {1'b0, s1_b_q} - {1'b0, s1_r_q}; off = HW'(OFF_G); end
      SEL_B:   begin diff = {1'b0, s1_r_q} - {1'b0, s1_g_q}; off = HW'(OFF_B); end
      default: begin diff = {1'b0, s1_g_q} - {1'b0, s1_b_q}; off = '0;        end
    endcase
    neg   = diff[CW];
    adiff = neg ? CW'(-diff) : diff[CW-1:0];

    h_int = int'(m_off) + (m_neg ? -int'(q_h) : int'(q_h));
    if (h_int < 0) h_int = h_int + WRAP;

    if (en) begin
      s1_vld_d   = in_valid;
      s1_r_d     = in_r;
      s1_g_d     = in_g;
      s1_b_d     = in_b;
      s1_max_d   = mx;
      s1_delta_d = mx - mn;
      s1_sel_d   = sel;
      s1_sb_d    = in_sb;

      s2_vld_d   = s1_vld_q;
      s2_hnum_d  = HNW'(adiff) * HNW'(K);
      s2_snum_d  = {s1_delta_q, CW'(0)} - {CW'(0), s1_delta_q};
      s2_delta_d = s1_delta_q;
      s2_meta_d  = {neg, off, s1_delta_q == '0, s1_max_q, s1_sb_q};

      meta_d[0] = s2_meta_q;
      for (int i = 1; i < CW; i++) meta_d[i] = meta_q[i-1];

      out_vld_d = h_vld && s_vld;
      out_h_d   = m_dz ? '0 : HW'(h_int);
      out_s_d   = m_dz ? '0 : q_s;
      out_v_d   = m_max;
      out_sb_d  = m_sb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;  s1_r_q <= '0;  s1_g_q <= '0;  s1_b_q <= '0;
      s1_max_q <= '0;  s1_delta_q <= '0;  s1_sel_q <= SEL_R;  s1_sb_q <= '0;
      s2_vld_q <= 1'b0;  s2_hnum_q <= '0;  s2_snum_q <= '0;
      s2_delta_q <= '0;  s2_meta_q <= '0;
      meta_q <= '{default: '0};
      out_vld_q <= 1'b0;  out_h_q <= '0;  out_s_q <= '0;  out_v_q <= '0;  out_sb_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;  s1_r_q <= s1_r_d;  s1_g_q <= s1_g_d;  s1_b_q <= s1_b_d;
      s1_max_q <= s1_max_d;  s1_delta_q <= s1_delta_d;  s1_sel_q <= s1_sel_d;  s1_sb_q <= s1_sb_d;
      s2_vld_q <= s2_vld_d;  s2_hnum_q <= s2_hnum_d;  s2_snum_q <= s2_snum_d;
      s2_delta_q <= s2_delta_d;  s2_meta_q <= s2_meta_d;
      meta_q <= meta_d;
      out_vld_q <= out_vld_d;  out_h_q <= out_h_d;  out_s_q <= out_s_d;
      out_v_q <= out_v_d;  out_sb_q <= out_sb_d;
    end
  end

  hsv_pipe_divider #(.NW(HNW), .DW(CW), .QW(CW)) u_hue_div (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .in_vld  (s2_vld_q),
    .in_num  (s2_hnum_q),
    .in_den  (s2_delta_q),
    .out_vld (h_vld),
    .out_quo (q_h)
  );

  hsv_pipe_divider #(.NW(2*CW), .DW(CW), .QW(CW)) u_sat_div (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .in_vld  (s2_vld_q),
    .in_num  (s2_snum_q),
    .in_den  (s2_max),
    .out_vld (s_vld),
    .out_quo (q_s)
  );

  assign out_valid = out_vld_q;
  assign out_h     = out_h_q;
  assign out_s     = out_s_q;
  assign out_v     = out_v_q;
  assign out_sb    = out_sb_q;

endmodule
